isp_oecf_lut_loader: RTL
========================

# isp_oecf_lut_loader

Sequencer that programs the four OECF lookup tables (R, GR, GB, B) through their tuning-side RAM ports from a host entry stream. It optionally reads every table back and checks it against a write checksum. It sits between the configuration/host path and the tuning ports of the OECF stage. Table clocks are tied to `pclk` at the integration level.

## Interface
- `BITS`, 8, pixel/LUT data width; each table holds 2**BITS entries of BITS bits
- `SYNC_VBLANK`, 1, when 1, entries are accepted only while `in_vsync`=1 (vertical blanking)
- `CHK_W`, 16, checksum width
- `pclk`  in  1  pixel/config clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_vsync`  in  1  frame vsync of the pixel stream; 1 = blanking
- `start`  in  1  single-cycle load request; ignored while `busy`=1
- `verify_en`  in  1  sampled on accepted `start`; 1 = run the readback pass
- `cfg_valid`  in  1  host entry valid
- `cfg_ready`  out  1  loader accepts an entry
- `cfg_data`  in  BITS  entry value, ordered R[0..N-1], GR[..], GB[..], B[..]
- `table_wen`  out  4  one-hot write enable; bit0=R, bit1=GR, bit2=GB, bit3=B
- `table_ren`  out  4  one-hot read enable, same bit mapping
- `table_addr`  out  BITS  shared table address
- `table_wdata`  out  BITS  shared write data
- `table_rdata`  in  4*BITS  read data; slice [k*BITS +: BITS] belongs to table k; one-cycle read latency
- `busy`  out  1  load or verify in progress
- `done`  out  1  one-cycle pulse at completion
- `err`  out  1  verify mismatch; held until the next accepted `start`
- `checksum`  out  CHK_W  write checksum; held after `done`

## Operation
- Reset state: all outputs are 0, state is IDLE, and the checksum registers are 0.
- FSM states:
  - IDLE, on `start`: clear both checksums and `err`, set tbl=0 and addr=0, then go to WRITE.
  - WRITE, after the handshake for tbl=3 and addr=2**BITS-1: go to VERIFY if verify was latched, else go to DONE.
  - VERIFY, after the read issue for tbl=3 and addr=max: go to FLUSH.
  - FLUSH: go to DONE.
  - DONE: go to IDLE.
- `cfg_ready` = (state==WRITE) && (!SYNC_VBLANK || in_vsync). It is combinational from state and `in_vsync`.
- A handshake is `cfg_valid && cfg_ready`. On each handshake:
  - Next cycle: `table_wen[tbl]`=1 for exactly one cycle, with `table_addr`=addr and `table_wdata`=cfg_data.
  - The write checksum accumulates `cfg_data` zero-extended, modulo 2**CHK_W.
  - addr increments. When addr wraps from 2**BITS-1 to 0, tbl increments.
- No handshake produces no write. `table_wen`=0, and addr/tbl hold.
- If `in_vsync` falls mid-load with SYNC_VBLANK=1:
  - Writing stalls and entries already written are kept.
  - Loading resumes in the next blanking period.
- VERIFY issues one read per cycle: `table_ren[tbl]`=1 with `table_addr`=addr. It walks all 4*2**BITS locations in write order and never stalls.
- Readback capture: one cycle after each read issue, the loader takes the `table_rdata` slice selected by the delayed tbl and accumulates it into the read checksum.
- In DONE, with verify latched: `err` is set if the read checksum != the write checksum.
- `busy`=1 in every state except IDLE. `done`=1 only in DONE.
- Reset mid-operation returns to IDLE with all outputs 0. Tables keep whatever was written; no rollback.
- `start` in a non-IDLE state is dropped. It is not queued.

## Timing
- A handshake at cycle t produces the write strobe at t+1.
- Sustained throughput is 1 entry/cycle.
- Without verify: the last handshake at t gives the last wen at t+1 and `done` at t+2.
- With verify: the last wen is at t+1. The first ren is at t+2 and the last ren at t+1+4*2**BITS. `done` and the final `err` appear at t+3+4*2**BITS.
- `table_wen` and `table_ren` are never both non-zero in the same cycle, and each is at most one-hot.

## Structure
- Package `isp_oecf_pkg` holds:
  - the state enum;
  - the table index constants TBL_R=0, TBL_GR=1, TBL_GB=2, TBL_B=3;
  - the default CHK_W.
- Sub-module `isp_oecf_lut_chk`: a CHK_W modulo accumulator with clear and enable. It is instantiated twice, once for write and once for read.

## Test plan
- BITS=8, SYNC_VBLANK=0, verify off, `cfg_data`=addr for every table, `cfg_valid` held at 1 → 1024 writes on consecutive cycles, `checksum`=0xFE00, `done` 2 cycles after the last handshake, `err`=0.
- Same load with verify on, against an ideal RAM model → 1024 reads, `err`=0, `done` at last handshake+1027.
- Verify on, with the RAM model corrupting GB[0x37] by +1 → `err`=1 after `done`. `err` clears on the next `start`.
- SYNC_VBLANK=1, `in_vsync` falls after 100 entries → `cfg_ready`=0 and no wen while `in_vsync`=0. On resume, writing continues at R[100]; final contents and `checksum` match the uninterrupted case.
- Random `cfg_valid` bubbles → wen only one cycle after handshakes, addresses contiguous, no entry skipped or duplicated.
- `start` pulsed mid-WRITE → ignored. `rst_n` low mid-WRITE → all outputs 0 and IDLE; a new `start` reloads from R[0].

Source files
------------

// File: rtl/isp_oecf_pkg.sv
// Shared types and constants for the OECF LUT loader: FSM states, table
// indices, default checksum width and the table-index to one-hot decode.
package isp_oecf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [1:0] TBL_R  = 2'd0;
  localparam logic [1:0] TBL_GR = 2'd1;
  localparam logic [1:0] TBL_GB = 2'd2;
  localparam logic [1:0] TBL_B  = 2'd3;

  localparam int CHK_W_DEF = 16;

  function automatic logic [3:0] tbl_onehot(input logic [1:0] tbl);
    logic [3:0] oh;
    case (tbl)
      TBL_R:   oh = 4'b0001;
      TBL_GR:  oh = 4'b0010;
      TBL_GB:  oh = 4'b0100;
      TBL_B:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/isp_oecf_lut_loader_if.sv
// Host entry stream plus the shared tuning-side port of the four OECF tables.
// The loader is the slave of the entry stream and drives the table port.
interface isp_oecf_lut_loader_if #(
  parameter int BITS = 8
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [BITS-1:0]   cfg_data;
  logic [3:0]        table_wen;
  logic [3:0]        table_ren;
  logic [BITS-1:0]   table_addr;
  logic [BITS-1:0]   table_wdata;
  logic [4*BITS-1:0] table_rdata;

  modport slave (
    input  cfg_valid, cfg_data, table_rdata,
    output cfg_ready, table_wen, table_ren, table_addr, table_wdata
  );

  modport master (
    output cfg_valid, cfg_data, table_rdata,
    input  cfg_ready, table_wen, table_ren, table_addr, table_wdata
  );

endinterface

// File: rtl/isp_oecf_lut_loader_chk.sv
// Modulo-2**CHK_W accumulator of zero-extended data words with synchronous
// clear; one copy sums written entries, another sums the readback.
module isp_oecf_lut_chk
  import isp_oecf_pkg::*;
#(
  parameter int CHK_W = CHK_W_DEF,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DW-1:0]    i_data,
  output logic [CHK_W-1:0] o_sum
);

  logic [CHK_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + CHK_W'(i_data);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/isp_oecf_lut_loader.sv
// Programs the R/GR/GB/B OECF tables from the host entry stream and can read
// all four back, flagging err when the readback sum differs from the write sum.
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | accepting entries, one registered table write per handshake
// VERIFY | one table read per cycle over all locations in write order
// FLUSH  | last read data in flight
// DONE   | one-cycle done pulse, checksum compare
module isp_oecf_lut_loader
  import isp_oecf_pkg::*;
#(
  parameter int BITS        = 8,
  parameter bit SYNC_VBLANK = 1'b1,
  parameter int CHK_W       = CHK_W_DEF
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 in_vsync,
  input  logic                 start,
  input  logic                 verify_en,
  isp_oecf_lut_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CHK_W-1:0]     checksum
);

  localparam logic [BITS-1:0] ADDR_MAX = '1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [1:0]      r_tbl;
  logic [BITS-1:0] r_addr;
  logic            r_verify;
  logic            r_last_wr;
  logic            r_err;
  logic [3:0]      r_wen;
  logic [BITS-1:0] r_wr_addr;
  logic [BITS-1:0] r_wr_data;
  logic            r_rd_vld;
  logic [1:0]      r_rd_tbl;

  logic             w_ready;
  logic             w_hs;
  logic             w_start_acc;
  logic             w_last_pos;
  logic             w_rd_issue;
  logic             w_mismatch;
  logic [BITS-1:0]  w_rd_slice;
  logic [CHK_W-1:0] w_wr_sum;
  logic [CHK_W-1:0] w_rd_sum;

  assign w_last_pos  = (r_tbl == TBL_B) && (r_addr == ADDR_MAX);
  // r_last_wr holds WRITE one extra cycle so the final strobe leaves before
  // the next phase, without accepting a 1025th entry.
  assign w_ready     = (r_state == ST_WRITE) && !r_last_wr && (!SYNC_VBLANK || in_vsync);
  assign w_hs        = bus.cfg_valid && w_ready;
  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_rd_issue  = (r_state == ST_VERIFY);
  assign w_rd_slice  = bus.table_rdata[r_rd_tbl*BITS +: BITS];
  assign w_mismatch  = r_verify && (w_rd_sum != w_wr_sum);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (r_last_wr) w_state_nxt = r_verify ? ST_VERIFY : ST_DONE;
      end
      ST_VERIFY: begin
        if (w_last_pos) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl     <= TBL_R;
      r_addr    <= '0;
      r_verify  <= 1'b0;
      r_last_wr <= 1'b0;
      r_err     <= 1'b0;
      r_wen     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_tbl  <= TBL_R;
    end else begin
      r_wen     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_vld  <= w_rd_issue;
      r_rd_tbl  <= r_tbl;
      if (w_start_acc) begin
        r_tbl     <= TBL_R;
        r_addr    <= '0;
        r_verify  <= verify_en;
        r_last_wr <= 1'b0;
        r_err     <= 1'b0;
      end else if (w_hs) begin
        r_wen     <= tbl_onehot(r_tbl);
        r_wr_addr <= r_addr;
        r_wr_data <= bus.cfg_data;
        r_addr    <= r_addr + BITS'(1);
        if (r_addr == ADDR_MAX) r_tbl <= r_tbl + 2'd1;
        r_last_wr <= w_last_pos;
      end else if (w_rd_issue) begin
        r_addr <= r_addr + BITS'(1);
        if (r_addr == ADDR_MAX) r_tbl <= r_tbl + 2'd1;
      end
      if ((r_state == ST_DONE) && w_mismatch) r_err <= 1'b1;
    end
  end

  isp_oecf_lut_chk #(.CHK_W(CHK_W), .DW(BITS)) u_chk_wr (
    .clk    (pclk),
    .rst_n  (rst_n),
    .i_clr  (w_start_acc),
    .i_en   (w_hs),
    .i_data (bus.cfg_data),
    .o_sum  (w_wr_sum)
  );

  isp_oecf_lut_chk #(.CHK_W(CHK_W), .DW(BITS)) u_chk_rd (
    .clk    (pclk),
    .rst_n  (rst_n),
    .i_clr  (w_start_acc),
    .i_en   (r_rd_vld),
    .i_data (w_rd_slice),
    .o_sum  (w_rd_sum)
  );

  // Read addresses come straight from the walk counter so the first read
  // lands the cycle after the last write strobe.
  assign bus.cfg_ready   = w_ready;
  assign bus.table_wen   = r_wen;
  assign bus.table_ren   = w_rd_issue ? tbl_onehot(r_tbl) : 4'b0000;
  assign bus.table_addr  = w_rd_issue ? r_addr : r_wr_addr;
  assign bus.table_wdata = r_wr_data;

  assign err      = r_err || ((r_state == ST_DONE) && w_mismatch);
  assign checksum = w_wr_sum;

endmodule
